// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD subtractor: FSM states, decimal
// constants and the width of one BCD digit.
package bcd_pkg;

   localparam int DIG_W     = 4;
   localparam int BCD_MAX   = 9;
   localparam int BCD_RADIX = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow: d = a - b - bin, wrapped by ten.
// Purely combinational; the parent time-multiplexes it across all digits.
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  logic [DIG_W-1:0] a,
   input  logic [DIG_W-1:0] b,
   input  logic             bin,
   output logic [DIG_W-1:0] d,
   output logic             bout
);

   // Operands are 0..9, so the raw difference spans -10..9 and fits 5 bits signed.
   logic signed [DIG_W:0] w_t;
   logic        [DIG_W:0] w_adj;

   assign w_t   = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({{DIG_W{1'b0}}, bin});
   assign w_adj = w_t + (DIG_W+1)'(BCD_RADIX);
   assign bout  = w_t[DIG_W];
   assign d     = bout ? w_adj[DIG_W-1:0] : w_t[DIG_W-1:0];

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: captures a and b on start, then resolves one
// digit per clock (LSD first) through a single shared digit subtractor.
module bcd_sub_serial
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIG_W*NDIG-1:0] a,
   input  logic [DIG_W*NDIG-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DIG_W*NDIG-1:0] diff,
   output logic                  borrow,
   output logic                  invalid
);

   localparam int W     = DIG_W * NDIG;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t             r_state;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_diff;
   logic               r_borrow;
   logic               r_invalid;
   logic               r_bin;
   logic [IDX_W-1:0]   r_idx;

   logic [DIG_W-1:0]   w_a_digits [NDIG];
   logic [DIG_W-1:0]   w_b_digits [NDIG];
   logic [NDIG-1:0]    w_nib_bad;
   logic               w_any_bad;
   logic [DIG_W-1:0]   w_d;
   logic               w_bout;

   // The validity decision must be made on the edge that captures, so it
   // looks at the live inputs rather than the operand registers.
   for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign w_a_digits[gi] = r_a[gi*DIG_W +: DIG_W];
      assign w_b_digits[gi] = r_b[gi*DIG_W +: DIG_W];
      assign w_nib_bad[gi]  = (a[gi*DIG_W +: DIG_W] > DIG_W'(BCD_MAX)) ||
                              (b[gi*DIG_W +: DIG_W] > DIG_W'(BCD_MAX));
   end

   assign w_any_bad = |w_nib_bad;

   bcd_digit_sub u_digit (
      .a    (w_a_digits[r_idx]),
      .b    (w_b_digits[r_idx]),
      .bin  (r_bin),
      .d    (w_d),
      .bout (w_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_diff    <= '0;
         r_borrow  <= 1'b0;
         r_invalid <= 1'b0;
         r_bin     <= 1'b0;
         r_idx     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_diff    <= '0;
                  r_borrow  <= 1'b0;
                  r_invalid <= w_any_bad;
                  r_bin     <= 1'b0;
                  r_idx     <= '0;
                  r_state   <= w_any_bad ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < NDIG; i++) begin
                  if (r_idx == IDX_W'(i))
                     r_diff[i*DIG_W +: DIG_W] <= w_d;
               end
               r_bin <= w_bout;
               r_idx <= r_idx + 1'b1;
               if (r_idx == IDX_W'(NDIG-1)) begin
                  r_borrow <= w_bout;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = (r_state == ST_DONE);
   assign diff    = r_diff;
   assign borrow  = r_borrow;
   assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboarded bench for bcd_sub_serial: a driver queues decimal-arithmetic
// expectations, a monitor retires them on each done pulse.
module tb_bcd_sub_serial;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         invalid;

   bcd_sub_serial #(.NDIG(NDIG)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .diff    (diff),
      .borrow  (borrow),
      .invalid (invalid)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         borrow;
      logic         invalid;
      int unsigned  start_cyc;
      int           lat;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: decode both operands to integers, subtract, re-encode modulo 10^NDIG.
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t   e;
      longint x   = 0;
      longint y   = 0;
      longint d;
      longint p   = 1;
      bit     bad = 0;
      int     na;
      int     nb;
      for (int i = NDIG - 1; i >= 0; i--) begin
         na = int'(av[i*4 +: 4]);
         nb = int'(bv[i*4 +: 4]);
         if (na > 9 || nb > 9) bad = 1;
         x = x * 10 + na;
         y = y * 10 + nb;
         p = p * 10;
      end
      e.a = av;
      e.b = bv;
      e.start_cyc = 0;
      if (bad) begin
         e.diff    = '0;
         e.borrow  = 1'b0;
         e.invalid = 1'b1;
         e.lat     = 1;
      end else begin
         d = x - y;
         e.borrow = (d < 0);
         if (d < 0) d = d + p;
         e.diff = '0;
         for (int i = 0; i < NDIG; i++) begin
            e.diff[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
         end
         e.invalid = 1'b0;
         e.lat     = NDIG + 1;
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < NDIG; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   // Monitor: retires one expectation per done pulse.
   exp_t         mon_e;
   logic         prev_done = 1'b0;
   logic [W-1:0] prev_diff = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (prev_done) begin
            check("done_width", {63'd0, done}, 64'd0);
            check("diff_hold", {48'd0, diff}, {48'd0, prev_diff});
         end
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               mon_e = sb.pop_front();
               check("diff", {48'd0, diff}, {48'd0, mon_e.diff});
               check("borrow", {63'd0, borrow}, {63'd0, mon_e.borrow});
               check("invalid", {63'd0, invalid}, {63'd0, mon_e.invalid});
               check("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
               $display("op a=%h b=%h diff=%h borrow=%0d invalid=%0d lat=%0d",
                        mon_e.a, mon_e.b, diff, borrow, invalid, cyc - mon_e.start_cyc);
            end
         end
         prev_done = done;
         prev_diff = diff;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   // Issues one start; returns #1 after the edge that sampled it.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      wait_idle();
      @(posedge clk);
      #1;
      a     = av;
      b     = bv;
      start = 1'b1;
      e = model(av, bv);
      e.start_cyc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           n;

      #12;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_diff", {48'd0, diff}, 64'd0);
      check("rst_borrow", {63'd0, borrow}, 64'd0);
      check("rst_invalid", {63'd0, invalid}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      issue(16'h4321, 16'h1234);
      issue(16'h0000, 16'h0001);
      issue(16'h9999, 16'h9999);
      issue(16'h1000, 16'h0999);
      issue(16'h00A0, 16'h0123);

      // Start pulses and operand changes while busy must be ignored.
      issue(16'h5000, 16'h0001);
      start = 1'b1;
      a = rand_bcd();
      b = rand_bcd();
      @(posedge clk);
      #1;
      a = rand_bcd();
      b = 16'h00F0;
      @(posedge clk);
      #1;
      start = 1'b0;

      for (int k = 0; k < 40; k++) begin
         ra = rand_bcd();
         rb = rand_bcd();
         if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 0)
               ra[$urandom_range(0, NDIG-1)*4 +: 4] = 4'($urandom_range(10, 15));
            else
               rb[$urandom_range(0, NDIG-1)*4 +: 4] = 4'($urandom_range(10, 15));
         end
         issue(ra, rb);
      end

      // Reset after two RUN cycles aborts the operation.
      issue(16'h8642, 16'h1357);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_diff", {48'd0, diff}, 64'd0);
      check("abort_borrow", {63'd0, borrow}, 64'd0);
      check("abort_invalid", {63'd0, invalid}, 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", {63'd0, done}, 64'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(16'h2000, 16'h0002);

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bcd_sub_serial.md
BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

Interface
REQ-001 The block SHALL expose parameter NDIG, default 4, meaning the number of BCD digits per operand (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 4*NDIG bits: BCD minuend, with digit 0 in bits [3:0].
REQ-006 The block SHALL have port b, input, 4*NDIG bits: BCD subtrahend, with the same digit order as a.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result as final.
REQ-009 The block SHALL have port diff, output, 4*NDIG bits: BCD result of a - b, as ten's complement when borrow=1.
REQ-010 The block SHALL have port borrow, output, 1 bit: final borrow out, 1 iff a < b.
REQ-011 The block SHALL have port invalid, output, 1 bit: set iff a latched nibble of a or b exceeds 9.

Function
REQ-012 The FSM SHALL have exactly three states (IDLE, RUN, DONE), and the state register SHALL drive busy and done directly.
REQ-013 In IDLE with start=1, the block SHALL capture a and b into internal registers on the same edge and clear diff, borrow, invalid, the digit index and the internal borrow.
REQ-014 If any captured nibble is greater than 9, the block SHALL go IDLE->DONE with invalid=1, diff=0, borrow=0, and SHALL perform no digit steps.
REQ-015 Otherwise the block SHALL go IDLE->RUN with digit index 0 and internal borrow 0.
REQ-016 In RUN, each clock SHALL process one digit, least significant digit first, as t = a_i - b_i - bin.
REQ-017 If t < 0, the block SHALL write diff digit i = t+10 and set bout=1; otherwise it SHALL write diff digit i = t and set bout=0.
REQ-018 bout SHALL become bin for digit i+1.
REQ-019 After digit NDIG-1 is written, the block SHALL load borrow with the final bout and go RUN->DONE.
REQ-020 Latency: with start sampled at edge 0, digit i SHALL be written at edge i+1, and done SHALL be high for exactly the cycle following edge NDIG.
REQ-021 For an invalid operand, done SHALL be high for the cycle following edge 0 (edge 1 for latency accounting).
REQ-022 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-023 diff, borrow and invalid SHALL hold their values from DONE until the next accepted start.
REQ-024 start SHALL be ignored in RUN and DONE, with no effect on the registered operands or outputs.
REQ-025 Changes on a or b after capture SHALL not affect the result.
REQ-026 Each digit step SHALL use only 5-bit signed intermediate width, and no binary conversion of whole operands SHALL occur.
REQ-027 Intermediate diff digits SHALL be observable but SHALL be considered final only when done=1.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE and the digit index to 0.
REQ-029 rst_n low SHALL asynchronously force busy=0, done=0, diff=0, borrow=0, invalid=0, and clear the operand registers and the internal borrow.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-031 After rst_n deasserts, the block SHALL accept start on the first clock edge.

Structure
REQ-032 A shared package bcd_pkg SHALL hold the FSM state typedef, the constants BCD_MAX=9 and BCD_RADIX=10, and the digit width 4.
REQ-033 The per-digit step SHALL be a combinational sub-module bcd_digit_sub (inputs a, b and bin; outputs d[3:0] and bout), instantiated once and time-multiplexed.
REQ-034 The NDIG-wide digit select and write SHALL be indexed slices in the parent module.

Verification
REQ-035 With NDIG=4, a=4321 and b=1234 (BCD hex), the bench SHALL check diff=3087, borrow=0, invalid=0, and done exactly 5 cycles after start.
REQ-036 With a=0000 and b=0001, the bench SHALL check diff=9999 and borrow=1 (full borrow ripple across all digits).
REQ-037 With a=9999 and b=9999, the bench SHALL check diff=0000 and borrow=0; with a=1000 and b=0999, it SHALL check diff=0001 and borrow=0.
REQ-038 With a=00A0 and any valid b, the bench SHALL check done one cycle after start, with invalid=1, diff=0000 and borrow=0.
REQ-039 When start pulses again while busy and a/b change mid-RUN, the bench SHALL check that the original result is produced and only one done pulse occurs.
REQ-040 When rst_n drops after 2 RUN cycles, the bench SHALL check that all outputs are 0 immediately, that no done occurs, and that a new start after release completes correctly.
